prog_ctrl: RTL and testbench
============================

Name: prog_ctrl

Overview:
- User-input front end that sits directly upstream of the clock generator (dcm).
- Debounces three raw push-buttons: up, down and apply.
- Holds a 3-bit pending frequency selection and issues a registered prog_in value plus a one-cycle update pulse to the clock generator.
- Waits for the generator's prog_out to echo the issued value; flags a timeout error if it does not.

Parameters:
- DEBOUNCE_CNT, 1000000: consecutive stable cycles required before a button change is accepted (10 ms at 100 MHz).
- ACK_TIMEOUT, 1024: maximum WAIT_ACK cycles allowed for prog_out to match prog_in.

Ports:
- clk  in  1  100 MHz system clock; all state on its rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- btn_up  in  1  raw, asynchronous button: increment selection.
- btn_down  in  1  raw, asynchronous button: decrement selection.
- btn_apply  in  1  raw, asynchronous button: send selection to the clock generator.
- prog_out_in  in  3  frequency code currently generated, from the clock generator's prog_out.
- prog_in  out  3  issued frequency code, to the clock generator's prog_in; registered.
- update  out  1  one-cycle pulse, to the clock generator's update.
- sel  out  3  pending selection, for display.
- busy  out  1  high in ISSUE and WAIT_ACK.
- err  out  1  sticky acknowledge-timeout flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - prog_in=0, update=0, sel=0, busy=0, err=0.
  - FSM goes to IDLE.
  - Synchronizers, stable states, debounce counters and ack timer cleared.
- Per-button input path:
  - Two-flop synchronizer, then a debouncer holding a stable state and a counter.
  - Counter clears on any cycle where the synced value equals the stable state.
  - Otherwise the counter increments; when it reaches DEBOUNCE_CNT-1 the stable state takes the synced value and the counter clears.
  - Press pulse is registered: high for exactly one cycle, the cycle after the stable state rises 0->1.
  - Release generates no pulse.
  - Glitches shorter than DEBOUNCE_CNT cycles produce no pulse.
- Selection register sel, updated in any FSM state:
  - up pulse alone: sel+1, saturating at 7.
  - down pulse alone: sel-1, saturating at 0.
  - up and down in the same cycle: no change.
- FSM:
  - IDLE: busy=0. On an apply pulse: prog_in<=sel, go to ISSUE. Other inputs do not change state.
  - ISSUE (one cycle): update=1, busy=1. Ack timer cleared. Always go to WAIT_ACK.
  - WAIT_ACK: busy=1, timer increments each cycle.
    - If prog_out_in==prog_in: err<=0, go to IDLE. The match check has priority over timeout.
    - Else, if timer==ACK_TIMEOUT-1: err<=1, go to IDLE.
- Apply pulses in ISSUE or WAIT_ACK are dropped, not queued.
- prog_in changes only on the IDLE->ISSUE transition and holds otherwise.
- update is never high outside ISSUE; it is never high two cycles in a row.
- sel changes during busy do not affect the prog_in already in flight.
- err stays set until the next successful match, or until reset.
- Reset asserted mid-transaction aborts it immediately; update is low during and after reset.
- Latency, apply to update: a clean btn_apply rising edge yields update high exactly DEBOUNCE_CNT+4 cycles after the first clock edge that samples btn_apply=1:
  - 2 synchronizer cycles
  - DEBOUNCE_CNT debounce cycles
  - 1 pulse-register cycle
  - 1 FSM cycle into ISSUE

Test Plan:
- Reset/default (DEBOUNCE_CNT=4, ACK_TIMEOUT=8): hold rst=0 with buttons toggling -> all outputs 0. Release rst -> outputs stay 0, FSM in IDLE.
- Debounce and saturation: 3-cycle btn_up glitch -> sel stays 0. Then 9 clean up presses -> sel steps 1..7 and holds at 7. Then 8 down presses -> sel reaches 0 and holds.
- Issue and ack: sel=5, clean apply press -> update high for exactly 1 cycle at DEBOUNCE_CNT+4 cycles after sampling, prog_in=5, busy=1. Model drives prog_out_in=5 three cycles later -> busy=0, err=0.
- Timeout: sel=3, apply, prog_out_in held at 0 -> busy stays high for 8 WAIT_ACK cycles, then err=1, busy=0, prog_in stays 3. A next successful apply/ack clears err.
- Busy interaction: during WAIT_ACK press apply and up -> no second update pulse, sel increments, prog_in unchanged.
- Reset mid-operation: assert rst=0 during WAIT_ACK -> immediate prog_in=0, busy=0, err=0, update=0. After release, FSM is idle and accepts a new apply.

Source files
------------

// File: rtl/prog_ctrl.sv
// prog_ctrl: push-button front end for the clock generator.
// Debounces up/down/apply buttons, keeps a pending 3-bit frequency selection,
// issues it to the generator with a one-cycle update pulse and waits for the
// generator to echo it back, flagging a sticky error on acknowledge timeout.
module prog_ctrl #(
    parameter int DEBOUNCE_CNT = 1000000,
    parameter int ACK_TIMEOUT  = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_apply,
    input  logic [2:0] prog_out_in,
    output logic [2:0] prog_in,
    output logic       update,
    output logic [2:0] sel,
    output logic       busy,
    output logic       err
);

    localparam int DB_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam int TM_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CNT - 1);
    localparam logic [TM_W-1:0] TM_LAST = TM_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_ACK = 2'd2
    } state_t;

    // Button bit order throughout: [0]=up, [1]=down, [2]=apply
    logic [2:0]      w_btn_raw;
    logic [2:0]      r_sync1;
    logic [2:0]      r_sync2;
    logic [2:0]      r_stable;
    logic [2:0]      r_stable_d;
    logic [2:0]      r_press;
    logic            w_up;
    logic            w_down;
    logic            w_apply;
    state_t          r_state;
    logic [TM_W-1:0] r_timer;

    assign w_btn_raw = {btn_apply, btn_down, btn_up};
    assign w_up      = r_press[0];
    assign w_down    = r_press[1];
    assign w_apply   = r_press[2];

    // Two-flop synchronizer for the asynchronous button inputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_debounce
        logic [DB_W-1:0] r_db_cnt;

        // Accept a new level only after it has persisted DEBOUNCE_CNT cycles
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_stable[g] <= 1'b0;
                r_db_cnt    <= '0;
            end else if (r_sync2[g] == r_stable[g]) begin
                r_db_cnt    <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_stable[g] <= r_sync2[g];
                r_db_cnt    <= '0;
            end else begin
                r_db_cnt    <= r_db_cnt + DB_W'(1);
            end
        end
    end

    // Registered one-cycle press pulse on each debounced 0->1 transition
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stable_d <= '0;
            r_press    <= '0;
        end else begin
            r_stable_d <= r_stable;
            r_press    <= r_stable & ~r_stable_d;
        end
    end

    // Pending selection: saturating up/down, simultaneous presses cancel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel <= 3'd0;
        end else if (w_up && !w_down && sel != 3'd7) begin
            sel <= sel + 3'd1;
        end else if (w_down && !w_up && sel != 3'd0) begin
            sel <= sel - 3'd1;
        end
    end

    // Issue/acknowledge FSM; apply presses while busy are simply dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            prog_in <= 3'd0;
            update  <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    update <= 1'b0;
                    busy   <= 1'b0;
                    if (w_apply) begin
                        prog_in <= sel;
                        update  <= 1'b1;
                        busy    <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    update  <= 1'b0;
                    busy    <= 1'b1;
                    r_timer <= '0;
                    r_state <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    update <= 1'b0;
                    // A matching echo wins even on the final timeout cycle
                    if (prog_out_in == prog_in) begin
                        err     <= 1'b0;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_timer == TM_LAST) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + TM_W'(1);
                    end
                end
                default: begin
                    update  <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_ctrl.sv
// tb_prog_ctrl: directed test-plan scenarios followed by randomized button,
// acknowledge and reset activity, all checked against a behavioural model.
`timescale 1ns/1ps
module tb_prog_ctrl;

    localparam int DB = 4;
    localparam int AT = 8;

    logic       clk;
    logic       rst;
    logic       btn_up;
    logic       btn_down;
    logic       btn_apply;
    logic [2:0] prog_out_in;
    logic [2:0] prog_in;
    logic       update;
    logic [2:0] sel;
    logic       busy;
    logic       err;

    int n_cmp = 0;
    int n_err = 0;

    prog_ctrl #(.DEBOUNCE_CNT(DB), .ACK_TIMEOUT(AT)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_apply  (btn_apply),
        .prog_out_in(prog_out_in),
        .prog_in    (prog_in),
        .update     (update),
        .sel        (sel),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Raw samples per button, newest first: m_hist[b][0] = sample of previous edge.
    bit m_hist [3][0:DB];
    bit m_stable [3];
    bit m_rose [3];
    bit m_pulse [3];
    int m_sel, m_prog, m_age;
    bit m_busy, m_err, m_update;

    function automatic bit raw_btn(input int b);
        case (b)
            0:       return btn_up;
            1:       return btn_down;
            default: return btn_apply;
        endcase
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k <= DB; k++) m_hist[b][k] = 1'b0;
            m_stable[b] = 1'b0;
            m_rose[b]   = 1'b0;
            m_pulse[b]  = 1'b0;
        end
        m_sel = 0; m_prog = 0; m_age = 0;
        m_busy = 1'b0; m_err = 1'b0; m_update = 1'b0;
    endtask

    task automatic model_edge();
        bit p [3];
        bit all_diff;
        for (int b = 0; b < 3; b++) begin
            p[b]       = m_pulse[b];
            m_pulse[b] = m_rose[b];
            // Level accepted once the last DB synchronized samples all disagree with it
            all_diff = 1'b1;
            for (int k = 1; k <= DB; k++)
                if (m_hist[b][k] == m_stable[b]) all_diff = 1'b0;
            m_rose[b] = 1'b0;
            if (all_diff) begin
                m_rose[b]   = !m_stable[b];
                m_stable[b] = !m_stable[b];
            end
            for (int k = DB; k >= 1; k--) m_hist[b][k] = m_hist[b][k-1];
            m_hist[b][0] = raw_btn(b);
        end
        // Transaction: m_age = cycles since the issue cycle
        if (!m_busy) begin
            if (p[2]) begin
                m_prog = m_sel;
                m_busy = 1'b1;
                m_age  = 0;
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else begin
            if (int'(prog_out_in) == m_prog) begin
                m_err = 1'b0; m_busy = 1'b0;
            end else if (m_age == AT) begin
                m_err = 1'b1; m_busy = 1'b0;
            end else begin
                m_age++;
            end
        end
        if (p[0] && !p[1]) m_sel = (m_sel == 7) ? 7 : m_sel + 1;
        else if (p[1] && !p[0]) m_sel = (m_sel == 0) ? 0 : m_sel - 1;
        m_update = m_busy && (m_age == 0);
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_outputs();
        chk("update",  8'(update),  8'(m_update));
        chk("busy",    8'(busy),    8'(m_busy));
        chk("sel",     8'(sel),     8'(m_sel));
        chk("prog_in", 8'(prog_in), 8'(m_prog));
        chk("err",     8'(err),     8'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_edge();
        @(negedge clk);
        chk_outputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       btn_up    = v;
            1:       btn_down  = v;
            default: btn_apply = v;
        endcase
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b1);
        ticks(DB + 3);
        set_btn(b, 1'b0);
        ticks(DB + 3);
    endtask

    // Raise apply and count edges (from the first sampling edge) until update
    task automatic apply_wait(output int lat);
        btn_apply = 1'b1;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            lat++;
            if (update === 1'b1) break;
        end
        chk("update_seen", 8'(update), 8'd1);
    endtask

    task automatic assert_reset();
        rst = 1'b0;
        model_reset();
        #1;
        chk_outputs();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, cnt, ups, hold [3], resp_cnt;
        rst = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_apply = 1'b0;
        prog_out_in = 3'd0;
        model_reset();

        // Reset held with buttons toggling
        for (int i = 0; i < 6; i++) begin
            btn_up = 1'(i); btn_down = 1'(~i); btn_apply = 1'(i >> 1);
            tick();
            chk("rst_update", 8'(update), 8'd0);
            chk("rst_busy",   8'(busy),   8'd0);
            chk("rst_sel",    8'(sel),    8'd0);
            chk("rst_prog",   8'(prog_in), 8'd0);
            chk("rst_err",    8'(err),    8'd0);
        end
        btn_up = 1'b0; btn_down = 1'b0; btn_apply = 1'b0;
        rst = 1'b1;
        ticks(DB + 4);
        chk("idle_busy", 8'(busy), 8'd0);
        chk("idle_sel",  8'(sel),  8'd0);

        // Short glitch is rejected
        btn_up = 1'b1; ticks(DB - 1); btn_up = 1'b0; ticks(10);
        chk("glitch_sel", 8'(sel), 8'd0);

        // Saturating up, then saturating down
        for (int i = 0; i < 9; i++) begin
            press(0);
            chk("up_sel", 8'(sel), 8'((i + 1 > 7) ? 7 : i + 1));
        end
        for (int i = 0; i < 8; i++) begin
            press(1);
            chk("down_sel", 8'(sel), 8'((6 - i < 0) ? 0 : 6 - i));
        end

        // Issue and acknowledge with latency measurement
        for (int i = 0; i < 5; i++) press(0);
        chk("sel5", 8'(sel), 8'd5);
        apply_wait(lat);
        chk("latency", 8'(lat), 8'(DB + 4));
        chk("iss_prog", 8'(prog_in), 8'd5);
        chk("iss_busy", 8'(busy), 8'd1);
        btn_apply = 1'b0;
        tick();
        chk("upd_one_cycle", 8'(update), 8'd0);
        ticks(2);
        prog_out_in = 3'd5;
        ticks(2);
        chk("ack_busy", 8'(busy), 8'd0);
        chk("ack_err",  8'(err),  8'd0);
        ticks(DB + 3);

        // Timeout
        prog_out_in = 3'd0;
        press(1); press(1);
        chk("sel3", 8'(sel), 8'd3);
        apply_wait(lat);
        btn_apply = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy !== 1'b1) break;
            cnt++;
        end
        chk("wait_cycles", 8'(cnt), 8'(AT));
        chk("to_err",  8'(err),     8'd1);
        chk("to_busy", 8'(busy),    8'd0);
        chk("to_prog", 8'(prog_in), 8'd3);
        ticks(DB + 3);
        prog_out_in = 3'd3;
        apply_wait(lat);
        btn_apply = 1'b0;
        ticks(2);
        chk("clr_err",  8'(err),  8'd0);
        chk("clr_busy", 8'(busy), 8'd0);
        ticks(DB + 3);

        // Apply and up while waiting for acknowledge
        prog_out_in = 3'd0;
        btn_apply = 1'b1; ticks(DB);
        btn_apply = 1'b0; ticks(DB);
        chk("busy_upd", 8'(update), 8'd1);
        btn_apply = 1'b1; btn_up = 1'b1;
        ups = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (update === 1'b1) ups++;
        end
        btn_apply = 1'b0; btn_up = 1'b0;
        ticks(DB + 3);
        chk("dropped_updates", 8'(ups), 8'd0);
        chk("busy_sel",  8'(sel),     8'd4);
        chk("busy_prog", 8'(prog_in), 8'd3);
        chk("busy_err",  8'(err),     8'd1);

        // Reset in the middle of a transaction
        apply_wait(lat);
        btn_apply = 1'b0;
        ticks(2);
        chk("mid_busy", 8'(busy), 8'd1);
        assert_reset();
        chk("mr_prog",   8'(prog_in), 8'd0);
        chk("mr_busy",   8'(busy),    8'd0);
        chk("mr_err",    8'(err),     8'd0);
        chk("mr_update", 8'(update),  8'd0);
        ticks(2);
        chk("mr_update_hold", 8'(update), 8'd0);
        rst = 1'b1;
        ticks(DB + 3);
        apply_wait(lat);
        chk("post_rst_lat", 8'(lat), 8'(DB + 4));
        btn_apply = 1'b0;
        ticks(2);
        chk("post_rst_busy", 8'(busy), 8'd0);
        ticks(DB + 3);

        // Randomized activity
        for (int b = 0; b < 3; b++) hold[b] = $urandom_range(1, 10);
        resp_cnt = -1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int b = 0; b < 3; b++) begin
                hold[b]--;
                if (hold[b] <= 0) begin
                    set_btn(b, !raw_btn(b));
                    hold[b] = $urandom_range(1, 10);
                end
            end
            if (m_update) begin
                resp_cnt = $urandom_range(0, 12);
                prog_out_in = 3'($urandom_range(0, 7));
            end else if (resp_cnt > 0) begin
                resp_cnt--;
            end else if (resp_cnt == 0) begin
                prog_out_in = 3'(m_prog);
                resp_cnt = -1;
            end
            if (!rst) rst = 1'b1;
            else if ($urandom_range(0, 499) == 0) begin
                assert_reset();
                resp_cnt = -1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
